nvm_loader: RTL and testbench



---
 rtl/nvm_loader_pkg.sv | 24 ++
 rtl/byte_packer.sv | 52 +++++
 rtl/nvm_loader.sv | 209 ++++++++++++++++++++
 tb/tb_nvm_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvm_loader_pkg.sv
// Shared types and constants for the NVM byte-stream loader.
package nvm_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      CNT   = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      CHK   = 3'd5
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CHK     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // 8-bit modular add used for the running data checksum
   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream; first byte lands in bits [7:0].
module byte_packer
   import nvm_loader_pkg::*;
#(
   parameter int BYTES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic [BYTES*8-1:0] word,
   output logic               word_full
);

   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0]   byte_idx_r;
   logic [BYTES*8-1:0] word_r;

   // Flags that the byte being taken now fills the final lane of the word
   always_comb begin
      if (byte_valid && (byte_idx_r == LAST_IDX)) begin
         word_full = 1'b1;
      end else begin
         word_full = 1'b0;
      end
   end

   // Lane write and index advance; index wraps to 0 once the word is complete
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_idx_r <= '0;
         word_r     <= '0;
      end else if (byte_valid) begin
         word_r[{byte_idx_r, 3'b000} +: 8] <= byte_data;
         if (byte_idx_r == LAST_IDX) begin
            byte_idx_r <= '0;
         end else begin
            byte_idx_r <= byte_idx_r + IDX_ONE;
         end
      end else begin
         byte_idx_r <= byte_idx_r;
         word_r     <= word_r;
      end
   end

   assign word = word_r;

endmodule

// File: rtl/nvm_loader.sv
// Frame parser feeding sequential single-cycle writes into nvm_mem; holds the CPU during a frame.
module nvm_loader
   import nvm_loader_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   output logic                      rx_ready,
   output logic                      nvm_we,
   output logic [MEM_ADDR_WIDTH-1:0] nvm_addr,
   output logic [MEM_DATA_WIDTH-1:0] nvm_wd,
   output logic                      cpu_hold,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [1:0]                err_cause
);

   localparam int BYTES = MEM_DATA_WIDTH / 8;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0]          TMO_ONE  = TMO_W'(1);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

   loader_state_t             state_r;
   logic [1:0]                fld_idx_r;
   logic [23:0]               addr_raw_r;   // first three address bytes, oldest lowest
   logic [MEM_ADDR_WIDTH-1:0] addr_r;
   logic [15:0]               cnt_r;
   logic [7:0]                sum_r;
   logic [TMO_W-1:0]          tmo_r;
   logic                      rx_ready_r;
   logic                      nvm_we_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      err_r;
   logic [1:0]                err_cause_r;

   logic                      accept_s;
   logic                      sync_s;
   logic                      pack_valid_s;
   logic                      word_full_s;
   logic                      tmo_hit_s;
   logic [31:0]               addr_next_s;
   logic [15:0]               cnt_next_s;
   logic [7:0]                sum_next_s;
   logic [MEM_DATA_WIDTH-1:0] word_s;

   // Handshake decode and next-value helpers for the little-endian fields
   always_comb begin
      accept_s    = rx_valid && rx_ready_r;
      addr_next_s = {rx_data, addr_raw_r};
      cnt_next_s  = {rx_data, cnt_r[15:8]};
      sum_next_s  = sum8(sum_r, rx_data);
      if ((state_r == IDLE) && accept_s && (rx_data == SYNC_BYTE)) begin
         sync_s = 1'b1;
      end else begin
         sync_s = 1'b0;
      end
      if ((state_r == DATA) && accept_s) begin
         pack_valid_s = 1'b1;
      end else begin
         pack_valid_s = 1'b0;
      end
      if ((state_r != IDLE) && (state_r != WRITE) && !accept_s && (tmo_r == TMO_LAST)) begin
         tmo_hit_s = 1'b1;
      end else begin
         tmo_hit_s = 1'b0;
      end
   end

   byte_packer #(
      .BYTES (BYTES)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (sync_s),
      .byte_valid (pack_valid_s),
      .byte_data  (rx_data),
      .word       (word_s),
      .word_full  (word_full_s)
   );

   // Inter-byte gap counter: idle in IDLE, frozen during WRITE, cleared by each accepted byte
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_r <= '0;
      end else if ((state_r == IDLE) || accept_s || tmo_hit_s) begin
         tmo_r <= '0;
      end else if (state_r == WRITE) begin
         tmo_r <= tmo_r;
      end else begin
         tmo_r <= tmo_r + TMO_ONE;
      end
   end

   // Frame FSM with address/count/checksum registers and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         fld_idx_r   <= 2'd0;
         addr_raw_r  <= 24'd0;
         addr_r      <= '0;
         cnt_r       <= 16'd0;
         sum_r       <= 8'd0;
         rx_ready_r  <= 1'b1;
         nvm_we_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         err_cause_r <= ERR_NONE;
      end else begin
         nvm_we_r <= 1'b0;
         done_r   <= 1'b0;
         if (tmo_hit_s) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rx_ready_r  <= 1'b1;
            err_r       <= 1'b1;
            err_cause_r <= ERR_TIMEOUT;
         end else begin
            case (state_r)
               IDLE: begin
                  if (sync_s) begin
                     state_r     <= ADDR;
                     busy_r      <= 1'b1;
                     fld_idx_r   <= 2'd0;
                     sum_r       <= 8'd0;
                     err_r       <= 1'b0;
                     err_cause_r <= ERR_NONE;
                  end
               end
               ADDR: begin
                  if (accept_s) begin
                     addr_raw_r <= {rx_data, addr_raw_r[23:8]};
                     if (fld_idx_r == 2'd3) begin
                        addr_r    <= addr_next_s[MEM_ADDR_WIDTH-1:0];
                        fld_idx_r <= 2'd0;
                        state_r   <= CNT;
                     end else begin
                        fld_idx_r <= fld_idx_r + 2'd1;
                     end
                  end
               end
               CNT: begin
                  if (accept_s) begin
                     cnt_r <= cnt_next_s;
                     if (fld_idx_r == 2'd1) begin
                        fld_idx_r <= 2'd0;
                        state_r   <= (cnt_next_s == 16'd0) ? CHK : DATA;
                     end else begin
                        fld_idx_r <= fld_idx_r + 2'd1;
                     end
                  end
               end
               DATA: begin
                  if (accept_s) begin
                     sum_r <= sum_next_s;
                     if (word_full_s) begin
                        state_r    <= WRITE;
                        nvm_we_r   <= 1'b1;
                        rx_ready_r <= 1'b0;
                     end
                  end
               end
               WRITE: begin
                  addr_r     <= addr_r + ADDR_ONE;
                  cnt_r      <= cnt_r - 16'd1;
                  rx_ready_r <= 1'b1;
                  state_r    <= (cnt_r == 16'd1) ? CHK : DATA;
               end
               CHK: begin
                  if (accept_s) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     if (sum_next_s == 8'h00) begin
                        done_r <= 1'b1;
                     end else begin
                        err_r       <= 1'b1;
                        err_cause_r <= ERR_CHK;
                     end
                  end
               end
               default: begin
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                  rx_ready_r <= 1'b1;
               end
            endcase
         end
      end
   end

   assign rx_ready  = rx_ready_r;
   assign nvm_we    = nvm_we_r;
   assign nvm_addr  = addr_r;
   assign nvm_wd    = word_s;
   assign cpu_hold  = busy_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign err_cause = err_cause_r;

endmodule

// File: tb/tb_nvm_loader.sv
// Directed bench for nvm_loader: a 32-bit-address instance and a 4-bit-address instance
// share one stimulus driver selected by 'sel'; writes are checked against a scoreboard.
module tb_nvm_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       sel;

   logic        rx_ready_a, nvm_we_a, cpu_hold_a, busy_a, done_a, err_a;
   logic [31:0] nvm_addr_a, nvm_wd_a;
   logic [1:0]  err_cause_a;
   logic        rx_ready_b, nvm_we_b, cpu_hold_b, busy_b, done_b, err_b;
   logic [3:0]  nvm_addr_b;
   logic [31:0] nvm_wd_b;
   logic [1:0]  err_cause_b;

   logic valid_a, valid_b;
   assign valid_a = rx_valid & ~sel;
   assign valid_b = rx_valid & sel;

   nvm_loader #(.MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut_a (
      .clk(clk), .rst(rst), .rx_valid(valid_a), .rx_data(rx_data), .rx_ready(rx_ready_a),
      .nvm_we(nvm_we_a), .nvm_addr(nvm_addr_a), .nvm_wd(nvm_wd_a), .cpu_hold(cpu_hold_a),
      .busy(busy_a), .done(done_a), .err(err_a), .err_cause(err_cause_a));

   nvm_loader #(.MEM_ADDR_WIDTH(4), .MEM_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .rst(rst), .rx_valid(valid_b), .rx_data(rx_data), .rx_ready(rx_ready_b),
      .nvm_we(nvm_we_b), .nvm_addr(nvm_addr_b), .nvm_wd(nvm_wd_b), .cpu_hold(cpu_hold_b),
      .busy(busy_b), .done(done_b), .err(err_b), .err_cause(err_cause_b));

   // outputs of the currently selected instance
   logic        rdy, o_we, o_hold, o_busy, o_done, o_err;
   logic [31:0] o_addr, o_wd;
   logic [1:0]  o_cause;
   assign rdy     = sel ? rx_ready_b : rx_ready_a;
   assign o_we    = sel ? nvm_we_b : nvm_we_a;
   assign o_addr  = sel ? {28'd0, nvm_addr_b} : nvm_addr_a;
   assign o_wd    = sel ? nvm_wd_b : nvm_wd_a;
   assign o_hold  = sel ? cpu_hold_b : cpu_hold_a;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_done  = sel ? done_b : done_a;
   assign o_err   = sel ? err_b : err_a;
   assign o_cause = sel ? err_cause_b : err_cause_a;

   typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
   wr_t qa[$];
   wr_t qb[$];
   wr_t ea, eb;

   int errors = 0;
   int checks = 0;
   int wr_cnt_a = 0;
   int wr_cnt_b = 0;
   int wr_base;

   logic [7:0] d [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer for instance A, plus cpu_hold/busy equality every cycle
   always @(negedge clk) begin
      if (nvm_we_a === 1'b1) begin
         wr_cnt_a++;
         checks++;
         assert (qa.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_write_a observed addr=%h wd=%h expected no write", nvm_addr_a, nvm_wd_a);
         end
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            checks++;
            assert ((nvm_addr_a === ea.a) && (nvm_wd_a === ea.d)) else begin
               errors++;
               $error("FAIL write_a observed=%h/%h expected=%h/%h", nvm_addr_a, nvm_wd_a, ea.a, ea.d);
            end
         end
      end
      checks++;
      assert (cpu_hold_a === busy_a) else begin
         errors++;
         $error("FAIL hold_eq_busy_a observed=%b expected=%b", cpu_hold_a, busy_a);
      end
   end

   // Scoreboard consumer for instance B (4-bit addresses)
   always @(negedge clk) begin
      if (nvm_we_b === 1'b1) begin
         wr_cnt_b++;
         checks++;
         assert (qb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_write_b observed addr=%h wd=%h expected no write", nvm_addr_b, nvm_wd_b);
         end
         if (qb.size() > 0) begin
            eb = qb.pop_front();
            checks++;
            assert (({28'd0, nvm_addr_b} === eb.a) && (nvm_wd_b === eb.d)) else begin
               errors++;
               $error("FAIL write_b observed=%h/%h expected=%h/%h", nvm_addr_b, nvm_wd_b, eb.a, eb.d);
            end
         end
      end
   end

   // Drive one byte and hold it until the selected instance accepts it
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rdy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", {31'd0, rdy}, 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Checksum byte making (sum of data bytes + chk) mod 256 zero
   function automatic logic [7:0] chk_of(input logic [7:0] dd [8], input int n);
      logic [7:0] s;
      s = 8'h00;
      for (int j = 0; j < n * 4; j++) s = s + dd[j];
      return 8'h00 - s;
   endfunction

   // Send a full frame of n (<=2) words and push the expected writes
   task automatic send_frame(input logic s, input logic [31:0] addr, input int n,
                             input logic [7:0] dd [8], input logic [7:0] cb);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         e.a = s ? ((addr + 32'(i)) & 32'h0000_000F) : (addr + 32'(i));
         e.d = {dd[4*i+3], dd[4*i+2], dd[4*i+1], dd[4*i]};
         if (s) qb.push_back(e); else qa.push_back(e);
      end
      send_byte(8'hA5);
      chk("hold_after_sync", {31'd0, o_hold}, 32'd1);
      for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
      send_byte(8'(n));
      send_byte(8'h00);
      for (int j = 0; j < n * 4; j++) send_byte(dd[j]);
      chk("hold_before_chk", {31'd0, o_hold}, 32'd1);
      send_byte(cb);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rx_ready"}, {31'd0, rdy}, 32'd1);
      chk({tag, "_we"}, {31'd0, o_we}, 32'd0);
      chk({tag, "_addr"}, o_addr, 32'd0);
      chk({tag, "_wd"}, o_wd, 32'd0);
      chk({tag, "_hold"}, {31'd0, o_hold}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
      chk({tag, "_cause"}, {30'd0, o_cause}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; sel = 1'b0;
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset("reset_a");

      // good frame: sum of data = 0x264, so the checksum byte is 0x9C
      wr_base = wr_cnt_a;
      send_frame(1'b0, 32'h10, 2, d, chk_of(d, 2));
      chk("good_chk_value", {24'd0, chk_of(d, 2)}, 32'h9C);
      chk("good_done", {31'd0, o_done}, 32'd1);
      chk("good_err", {31'd0, o_err}, 32'd0);
      chk("good_busy_end", {31'd0, o_busy}, 32'd0);
      chk("good_writes", 32'(wr_cnt_a - wr_base), 32'd2);
      chk("good_queue", 32'(qa.size()), 32'd0);
      @(posedge clk); #1;
      chk("good_done_pulse", {31'd0, o_done}, 32'd0);

      // same frame with a wrong checksum: words still land, then a checksum error
      wr_base = wr_cnt_a;
      send_frame(1'b0, 32'h10, 2, d, 8'h00);
      chk("bad_done", {31'd0, o_done}, 32'd0);
      chk("bad_err", {31'd0, o_err}, 32'd1);
      chk("bad_cause", {30'd0, o_cause}, 32'd1);
      chk("bad_writes", 32'(wr_cnt_a - wr_base), 32'd2);

      // reset coinciding with the last byte of a word
      wr_base = wr_cnt_a;
      send_byte(8'hA5);
      send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hEF; rst = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; rst = 1'b0;
      check_reset("rst_mid");
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_write", 32'(wr_cnt_a - wr_base), 32'd0);
      send_frame(1'b0, 32'h20, 1, d, chk_of(d, 1));
      chk("after_rst_done", {31'd0, o_done}, 32'd1);
      chk("after_rst_queue", 32'(qa.size()), 32'd0);

      // zero-length frame
      wr_base = wr_cnt_a;
      send_frame(1'b0, 32'h40, 0, d, 8'h00);
      chk("n0_done", {31'd0, o_done}, 32'd1);
      chk("n0_writes", 32'(wr_cnt_a - wr_base), 32'd0);

      // noise then address wrap on the 4-bit instance
      sel = 1'b1;
      wr_base = wr_cnt_b;
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("noise_busy", {31'd0, o_busy}, 32'd0);
      send_frame(1'b1, 32'h0000_000F, 2, d, chk_of(d, 2));
      chk("wrap_done", {31'd0, o_done}, 32'd1);
      chk("wrap_writes", 32'(wr_cnt_b - wr_base), 32'd2);
      chk("wrap_queue", 32'(qb.size()), 32'd0);
      sel = 1'b0;

      // stall after two data bytes: timeout lands 16 cycles after the last accepted byte
      wr_base = wr_cnt_a;
      send_byte(8'hA5);
      send_byte(8'h50); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      repeat (15) @(posedge clk);
      #1;
      chk("tmo_early_err", {31'd0, o_err}, 32'd0);
      chk("tmo_early_busy", {31'd0, o_busy}, 32'd1);
      @(posedge clk); #1;
      chk("tmo_err", {31'd0, o_err}, 32'd1);
      chk("tmo_cause", {30'd0, o_cause}, 32'd2);
      chk("tmo_idle", {31'd0, o_busy}, 32'd0);
      chk("tmo_no_done", {31'd0, o_done}, 32'd0);
      chk("tmo_no_write", 32'(wr_cnt_a - wr_base), 32'd0);
      send_byte(8'hA5);
      chk("sync_clears_err", {31'd0, o_err}, 32'd0);
      chk("sync_clears_cause", {30'd0, o_cause}, 32'd0);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00);
      chk("post_tmo_done", {31'd0, o_done}, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
